// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access unit: access-width encoding,
// FSM state codes and response fault codes.
package dmem_pkg;

  localparam int unsigned XLEN = 32;

  // Access width encoding carried on WidthSrc
  localparam logic [2:0] WIDTH_W  = 3'b000;
  localparam logic [2:0] WIDTH_B  = 3'b001;
  localparam logic [2:0] WIDTH_H  = 3'b010;
  localparam logic [2:0] WIDTH_BU = 3'b101;
  localparam logic [2:0] WIDTH_HU = 3'b110;

  // FSM state codes
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // Fault codes reported with RspValid
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_WIDTH    = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane alignment for one access.
// Ports:
//   off        in  byte offset within the word (addr[1:0])
//   width      in  access width code
//   mem_write  in  1 = store
//   write_data in  right-justified store data
//   be         out byte enables
//   wd         out store data shifted into its byte lanes
//   misaligned out access does not sit on its natural boundary
//   illegal    out width code unsupported for this direction
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]      off,
  input  logic [2:0]      width,
  input  logic            mem_write,
  input  logic [XLEN-1:0] write_data,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wd,
  output logic            misaligned,
  output logic            illegal
);

  // Decode width into enables and alignment/legality flags
  always_comb begin
    be         = 4'b0000;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (width)
      WIDTH_W: begin
        be         = 4'b1111;
        misaligned = (off != 2'b00);
      end
      WIDTH_H, WIDTH_HU: begin
        be         = 4'b0011 << off;
        misaligned = off[0];
        // Unsigned variants only make sense for loads
        illegal    = mem_write && (width == WIDTH_HU);
      end
      WIDTH_B, WIDTH_BU: begin
        be         = 4'b0001 << off;
        illegal    = mem_write && (width == WIDTH_BU);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign wd = write_data << {off, 3'b000};

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store unit: accepts one request at a time, drives the
// data memory port with aligned address/enables/data, waits for the
// acknowledge (with optional timeout) and returns lane-shifted load data.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   ReqValid/ReqReady          request handshake from the pipeline
//   MemWrite, ALUResult,
//   WriteData, WidthSrc        request fields, captured at acceptance
//   DmemReq/WE/Addr/BE/WD      memory port, held until DmemAck
//   DmemAck, DmemRD            memory completion and read data
//   RspValid, BaseResult,
//   Fault                      one-cycle response towards reduce
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ReqValid,
  output logic            ReqReady,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] WriteData,
  input  logic [2:0]      WidthSrc,
  output logic            DmemReq,
  output logic            DmemWE,
  output logic [XLEN-1:0] DmemAddr,
  output logic [3:0]      DmemBE,
  output logic [XLEN-1:0] DmemWD,
  input  logic            DmemAck,
  input  logic [XLEN-1:0] DmemRD,
  output logic            RspValid,
  output logic [XLEN-1:0] BaseResult,
  output logic [1:0]      Fault
);

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]      off_q, off_d;
  logic            ready_q, ready_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            rsp_q, rsp_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [1:0]      fault_q, fault_d;

  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wd;
  logic            al_misaligned;
  logic            al_illegal;
  logic            timeout_hit;

  // Alignment is evaluated on the request as it is accepted; its results are
  // captured into the port registers so they stay stable through WAIT.
  dmem_align u_align (
    .off        (ALUResult[1:0]),
    .width      (WidthSrc),
    .mem_write  (MemWrite),
    .write_data (WriteData),
    .be         (al_be),
    .wd         (al_wd),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    ready_d  = ready_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wd_d     = wd_q;
    rsp_d    = 1'b0;
    result_d = '0;
    fault_d  = FAULT_NONE;

    case (state_q)
      ST_IDLE: begin
        if (ReqValid && ready_q) begin
          ready_d = 1'b0;
          if (al_illegal) begin
            state_d = ST_FAULT;
            rsp_d   = 1'b1;
            fault_d = FAULT_WIDTH;
          end else if (al_misaligned) begin
            state_d = ST_FAULT;
            rsp_d   = 1'b1;
            fault_d = FAULT_MISALIGN;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = {ALUResult[XLEN-1:2], 2'b00};
            be_d    = al_be;
            wd_d    = al_wd;
            off_d   = ALUResult[1:0];
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // Ack takes priority over a simultaneous expiry
        if (DmemAck) begin
          state_d  = ST_RESP;
          req_d    = 1'b0;
          we_d     = 1'b0;
          rsp_d    = 1'b1;
          result_d = we_q ? '0 : (DmemRD >> {off_q, 3'b000});
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
          req_d   = 1'b0;
          we_d    = 1'b0;
          rsp_d   = 1'b1;
          fault_d = FAULT_TIMEOUT;
        end
      end
      default: begin
        // RESP and FAULT last one cycle
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      off_q    <= 2'b00;
      ready_q  <= 1'b1;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wd_q     <= '0;
      rsp_q    <= 1'b0;
      result_q <= '0;
      fault_q  <= FAULT_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      ready_q  <= ready_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wd_q     <= wd_d;
      rsp_q    <= rsp_d;
      result_q <= result_d;
      fault_q  <= fault_d;
    end
  end

  assign ReqReady   = ready_q;
  assign DmemReq    = req_q;
  assign DmemWE     = we_q;
  assign DmemAddr   = addr_q;
  assign DmemBE     = be_q;
  assign DmemWD     = wd_q;
  assign RspValid   = rsp_q;
  assign BaseResult = result_q;
  assign Fault      = fault_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed cases with literal
// expectations plus randomized transactions against a transaction-level model.
module tb_dmem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [2:0]  WidthSrc;
  logic        DmemReq;
  logic        DmemWE;
  logic [31:0] DmemAddr;
  logic [3:0]  DmemBE;
  logic [31:0] DmemWD;
  logic        DmemAck;
  logic [31:0] DmemRD;
  logic        RspValid;
  logic [31:0] BaseResult;
  logic [1:0]  Fault;

  dmem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .MemWrite   (MemWrite),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .WidthSrc   (WidthSrc),
    .DmemReq    (DmemReq),
    .DmemWE     (DmemWE),
    .DmemAddr   (DmemAddr),
    .DmemBE     (DmemBE),
    .DmemWD     (DmemWD),
    .DmemAck    (DmemAck),
    .DmemRD     (DmemRD),
    .RspValid   (RspValid),
    .BaseResult (BaseResult),
    .Fault      (Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expectations for the transaction in flight
  logic [31:0] exp_addr, exp_wd, exp_res;
  logic [3:0]  exp_be;
  logic        exp_we;
  logic [1:0]  exp_code;

  // Observation counters and last-seen values
  int          req_cnt = 0;
  int          rsp_cnt = 0;
  int          obs_nreq;
  logic [31:0] cap_addr, cap_wd, cap_res;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [1:0]  cap_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what a request must produce, from the width/alignment rules
  function automatic void model(input logic we, input logic [31:0] addr, input logic [2:0] w,
                                input logic [31:0] wdata, input logic [31:0] rd, input int ack_at,
                                output logic [1:0] code, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] res, output int nreq);
    int  off;
    int  nbytes;
    bit  legal;
    off    = int'(addr[1:0]);
    legal  = (w == 3'd0 || w == 3'd1 || w == 3'd2 || w == 3'd5 || w == 3'd6) &&
             !(we && (w == 3'd5 || w == 3'd6));
    nbytes = (w == 3'd0) ? 4 : ((w == 3'd2 || w == 3'd6) ? 2 : 1);
    be     = 4'(((1 << nbytes) - 1) << off);
    wd     = wdata << (8 * off);
    res    = 32'h0;
    nreq   = 0;
    if (!legal) code = 2'd2;
    else if ((off % nbytes) != 0) code = 2'd1;
    else if (ack_at >= TO) begin
      code = 2'd3;
      nreq = TO;
    end else begin
      code = 2'd0;
      nreq = ack_at + 1;
      res  = we ? 32'h0 : (rd >> (8 * off));
    end
  endfunction

  // Advance to the next falling edge and check whatever the DUT presents
  task automatic tick();
    @(negedge clk);
    if (reset_n) begin
      if (DmemReq) begin
        req_cnt++;
        check("dmem_addr", DmemAddr, {exp_addr[31:2], 2'b00});
        check("dmem_be", 32'(DmemBE), 32'(exp_be));
        check("dmem_wd", DmemWD, exp_wd);
        check("dmem_we", 32'(DmemWE), 32'(exp_we));
        cap_addr = DmemAddr; cap_be = DmemBE; cap_wd = DmemWD; cap_we = DmemWE;
      end
      if (RspValid) begin
        rsp_cnt++;
        check("fault", 32'(Fault), 32'(exp_code));
        check("base_result", BaseResult, exp_res);
        cap_fault = Fault; cap_res = BaseResult;
      end
    end
  endtask

  // Issue one request from an idle falling edge; returns at the next idle falling edge
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] w, input int ack_at, input logic [31:0] rd);
    int req0, rsp0, nreq;
    model(we, addr, w, wdata, rd, ack_at, exp_code, exp_be, exp_wd, exp_res, nreq);
    exp_addr = addr;
    exp_we   = we;
    req0 = req_cnt;
    rsp0 = rsp_cnt;
    check("req_ready_idle", 32'(ReqReady), 32'd1);
    ReqValid  = 1'b1;
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wdata;
    WidthSrc  = w;
    DmemAck   = 1'(($urandom));
    DmemRD    = $urandom;
    tick();
    // Upstream changes its fields freely once accepted
    ReqValid  = 1'b0;
    MemWrite  = 1'($urandom);
    ALUResult = $urandom;
    WriteData = $urandom;
    WidthSrc  = 3'($urandom);
    if (exp_code == 2'd0 || exp_code == 2'd3) begin
      for (int i = 0; i < TO && i <= ack_at; i++) begin
        DmemAck = (i == ack_at);
        DmemRD  = (i == ack_at) ? rd : $urandom;
        tick();
      end
    end
    obs_nreq = req_cnt - req0;
    check("rsp_valid_pulse", 32'(RspValid), 32'd1);
    check("rsp_count", 32'(rsp_cnt - rsp0), 32'd1);
    check("req_cycles", 32'(obs_nreq), 32'(nreq));
    check("req_ready_busy", 32'(ReqReady), 32'd0);
    DmemAck = 1'($urandom);
    DmemRD  = $urandom;
    tick();
    check("rsp_valid_drop", 32'(RspValid), 32'd0);
    check("req_low_after", 32'(DmemReq), 32'd0);
  endtask

  logic [31:0] r_addr;
  int          rsp_hold;

  initial begin
    reset_n   = 1'b0;
    ReqValid  = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = 32'h0;
    WriteData = 32'h0;
    WidthSrc  = 3'h0;
    DmemAck   = 1'b0;
    DmemRD    = 32'h0;
    #1;
    check("rst_dmem_req", 32'(DmemReq), 32'd0);
    check("rst_dmem_we", 32'(DmemWE), 32'd0);
    check("rst_dmem_be", 32'(DmemBE), 32'd0);
    check("rst_dmem_addr", DmemAddr, 32'h0);
    check("rst_dmem_wd", DmemWD, 32'h0);
    check("rst_rsp_valid", 32'(RspValid), 32'd0);
    check("rst_base_result", BaseResult, 32'h0);
    check("rst_fault", 32'(Fault), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("ready_after_reset", 32'(ReqReady), 32'd1);

    // Load word
    run_txn(1'b0, 32'h0000_0104, 32'h0, 3'b000, 0, 32'hDEAD_BEEF);
    check("lw_addr", cap_addr, 32'h0000_0104);
    check("lw_be", 32'(cap_be), 32'hF);
    check("lw_result", cap_res, 32'hDEAD_BEEF);
    check("lw_fault", 32'(cap_fault), 32'd0);
    // Byte unsigned, top lane
    run_txn(1'b0, 32'h0000_0103, 32'h0, 3'b101, 0, 32'hAB12_3456);
    check("lbu_be", 32'(cap_be), 32'h8);
    check("lbu_result", cap_res, 32'h0000_00AB);
    // Halfword, upper lanes
    run_txn(1'b0, 32'h0000_0102, 32'h0, 3'b010, 1, 32'h8001_7FFF);
    check("lh_be", 32'(cap_be), 32'hC);
    check("lh_result", cap_res, 32'h0000_8001);
    // Store half
    run_txn(1'b1, 32'h0000_0202, 32'h0000_CAFE, 3'b010, 2, 32'h5555_5555);
    check("sh_we", 32'(cap_we), 32'd1);
    check("sh_be", 32'(cap_be), 32'hC);
    check("sh_wd", cap_wd, 32'hCAFE_0000);
    check("sh_result", cap_res, 32'h0);
    check("sh_fault", 32'(cap_fault), 32'd0);
    // Faults
    run_txn(1'b0, 32'h0000_0105, 32'h0, 3'b000, 0, 32'h1);
    check("mis_fault", 32'(cap_fault), 32'd1);
    check("mis_no_req", 32'(obs_nreq), 32'd0);
    run_txn(1'b0, 32'h0000_0100, 32'h0, 3'b011, 0, 32'h1);
    check("width_fault", 32'(cap_fault), 32'd2);
    run_txn(1'b1, 32'h0000_0101, 32'h77, 3'b101, 0, 32'h1);
    check("sbu_fault", 32'(cap_fault), 32'd2);
    // Timeout, then ack exactly on the last WAIT cycle
    run_txn(1'b0, 32'h0000_0400, 32'h0, 3'b000, 100, 32'h1);
    check("to_fault", 32'(cap_fault), 32'd3);
    check("to_req_cycles", 32'(obs_nreq), 32'd4);
    check("to_result", cap_res, 32'h0);
    run_txn(1'b0, 32'h0000_0400, 32'h0, 3'b000, 3, 32'h0BAD_F00D);
    check("late_ack_fault", 32'(cap_fault), 32'd0);
    check("late_ack_result", cap_res, 32'h0BAD_F00D);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r_addr = $urandom;
      if (($urandom % 2) != 0) r_addr[0] = 1'b0;
      if (($urandom % 2) != 0) r_addr[1] = 1'b0;
      run_txn(1'($urandom), r_addr, $urandom, 3'($urandom_range(0, 7)),
              int'($urandom_range(0, 5)), $urandom);
    end

    // Asynchronous reset in the middle of WAIT
    exp_addr = 32'h0000_0300; exp_be = 4'hF; exp_wd = 32'h0; exp_we = 1'b0;
    exp_code = 2'd0; exp_res = 32'h0;
    ReqValid = 1'b1; MemWrite = 1'b0; ALUResult = 32'h0000_0300;
    WriteData = 32'h0; WidthSrc = 3'b000; DmemAck = 1'b0;
    tick();
    ReqValid = 1'b0;
    check("mid_wait_req", 32'(DmemReq), 32'd1);
    rsp_hold = rsp_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("async_req_drop", 32'(DmemReq), 32'd0);
    check("async_be_clear", 32'(DmemBE), 32'd0);
    check("async_addr_clear", DmemAddr, 32'h0);
    check("async_no_rsp", 32'(RspValid), 32'd0);
    tick();
    tick();
    #2 reset_n = 1'b1;
    #1;
    check("ready_after_release", 32'(ReqReady), 32'd1);
    tick();
    tick();
    check("abandoned_no_rsp", 32'(rsp_cnt - rsp_hold), 32'd0);
    run_txn(1'b0, 32'h0000_0300, 32'h0, 3'b000, 0, 32'h1234_5678);
    check("post_reset_result", cap_res, 32'h1234_5678);
    check("post_reset_fault", 32'(cap_fault), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
